// File: rtl/yarvi_harness_pkg.sv
// Shared definitions for the yarvi_soc host-side stream harness.
// Run-state encoding is visible on the state port, so the values are fixed.

package yarvi_harness_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } harness_state_e;

    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h04;

endpackage

// File: rtl/yarvi_sync_fifo.sv
// Synchronous FIFO with a register-array store, occupancy count and
// same-cycle push/pop; a push while full is accepted only alongside a pop.

module yarvi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/yarvi_stream_harness.sv
// Host-side stream endpoint for yarvi_soc: injects queued bytes on tx, captures rx,
// and tracks the run with a terminator detector, idle watchdog and optional rx stalls.

module yarvi_stream_harness
    import yarvi_harness_pkg::*;
#(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       INJ_DEPTH    = 16,
    parameter int unsigned       CAP_DEPTH    = 16,
    parameter int unsigned       TIMEOUT      = 50000,
    parameter logic [DATA_W-1:0] TERM_BYTE    = TERM_BYTE_DEFAULT,
    parameter int unsigned       STALL_PERIOD = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [DATA_W-1:0]                load_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [DATA_W-1:0]                tx_data,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    input  logic [DATA_W-1:0]                rx_data,
    output logic                             cap_valid,
    input  logic                             cap_ready,
    output logic [DATA_W-1:0]                cap_data,
    output logic [1:0]                       state,
    output logic [$clog2(TIMEOUT+1)-1:0]     idle_count
);

    localparam int unsigned IdleW   = $clog2(TIMEOUT + 1);
    localparam int unsigned StallW  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int unsigned InjCntW = $clog2(INJ_DEPTH) + 1;
    localparam int unsigned CapCntW = $clog2(CAP_DEPTH) + 1;

    harness_state_e     state_q;
    logic [IdleW-1:0]   idle_q;
    logic [StallW-1:0]  stall_q;

    logic               run;
    logic               stall;
    logic               load_hs;
    logic               tx_hs;
    logic               rx_hs;
    logic               cap_hs;
    logic               any_hs;
    logic               term_hit;
    logic               inj_empty;
    logic               cap_empty;
    logic [InjCntW-1:0] inj_count;
    logic [CapCntW-1:0] cap_count;

    assign run   = (state_q == S_RUN);
    assign stall = (STALL_PERIOD != 0) && (stall_q == StallW'(STALL_PERIOD - 1));

    // All handshake-facing outputs depend only on registered state.
    assign load_ready = (inj_count != InjCntW'(INJ_DEPTH));
    assign tx_valid   = run && !inj_empty;
    assign rx_ready   = run && (cap_count != CapCntW'(CAP_DEPTH)) && !stall;
    assign cap_valid  = !cap_empty;

    assign load_hs  = load_valid && load_ready;
    assign tx_hs    = tx_valid && tx_ready;
    assign rx_hs    = rx_valid && rx_ready;
    assign cap_hs   = cap_valid && cap_ready;
    assign any_hs   = tx_hs || rx_hs;
    assign term_hit = rx_hs && (rx_data == TERM_BYTE);

    assign state      = state_q;
    assign idle_count = idle_q;

    yarvi_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (load_hs),
        .wdata_i (load_data),
        .pop_i   (tx_hs),
        .rdata_o (tx_data),
        .empty_o (inj_empty),
        .count_o (inj_count)
    );

    yarvi_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (CAP_DEPTH)
    ) u_cap_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (rx_hs),
        .wdata_i (rx_data),
        .pop_i   (cap_hs),
        .rdata_o (cap_data),
        .empty_o (cap_empty),
        .count_o (cap_count)
    );

    // Run FSM and watchdog share one register block; DONE takes priority over TIMEOUT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idle_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        state_q <= S_RUN;
                        idle_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (term_hit) begin
                        state_q <= S_DONE;
                    end else if (!any_hs && (idle_q == IdleW'(TIMEOUT - 1))) begin
                        state_q <= S_TIMEOUT;
                    end
                    idle_q <= any_hs ? '0 : idle_q + IdleW'(1);
                end
                default: begin
                    state_q <= S_IDLE;
                    idle_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (run && (STALL_PERIOD > 1)) begin
            stall_q <= stall ? '0 : stall_q + StallW'(1);
        end
    end

endmodule
